// File: rtl/posit_acc_pkg.sv
// Shared definitions for the posit stream accumulator: FSM state encoding
// and helpers that build the special posit bit patterns for a given width.
package posit_acc_pkg;

    // Widest posit the helpers can describe.
    localparam int POSIT_MAX_N = 32;

    typedef enum logic [1:0] {
        FLUSH  = 2'd0,
        ACCUM  = 2'd1,
        DRAIN  = 2'd2,
        OUTPUT = 2'd3
    } acc_state_t;

    // All-zero pattern: the only encoding of zero in an n-bit posit.
    function automatic logic [POSIT_MAX_N-1:0] posit_zero(input int n);
        return POSIT_MAX_N'(0) << n;
    endfunction

    // NaR: sign bit set, every other bit of the n-bit posit clear.
    function automatic logic [POSIT_MAX_N-1:0] posit_nar(input int n);
        return POSIT_MAX_N'(1) << (n - 1);
    endfunction

endpackage

// File: rtl/posit_stream_accumulator.sv
// Reduces a last-delimited stream of posits to one sum by driving an
// external posit adder and feeding its partial sums back into it.
// Optional feature macro: POSIT_ACC_COUNT_EN adds the m_count beat counter.
module posit_stream_accumulator
    import posit_acc_pkg::*;
#(
    parameter int N       = 8,
    parameter int es      = 4,
    parameter int ADD_LAT = 6
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic [N-1:0] s_data,
    input  logic         s_valid,
    input  logic         s_last,
    output logic         s_ready,
    output logic [N-1:0] add_in1,
    output logic [N-1:0] add_in2,
    output logic         add_start,
    input  logic [N-1:0] add_result,
    input  logic         add_inf,
    input  logic         add_zero,
    input  logic         add_done,
    output logic [N-1:0] m_data,
    output logic         m_inf,
    output logic         m_zero,
    output logic         m_valid,
    input  logic         m_ready
`ifdef POSIT_ACC_COUNT_EN
    ,
    output logic [15:0]  m_count
`endif
);

    localparam int CNT_W = $clog2(ADD_LAT + 2);
    localparam logic [POSIT_MAX_N-1:0] NAR_WIDE  = posit_nar(N);
    localparam logic [POSIT_MAX_N-1:0] ZERO_WIDE = posit_zero(N);
    localparam logic [N-1:0]     NAR        = NAR_WIDE[N-1:0];
    localparam logic [N-1:0]     ZERO       = ZERO_WIDE[N-1:0];
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(ADD_LAT);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    if (N < 3 || N > POSIT_MAX_N) begin : g_bad_width
        $error("posit width N out of supported range");
    end
    if (es < 0 || es >= N) begin : g_bad_es
        $error("exponent width es must be smaller than N");
    end
    if (ADD_LAT < 1) begin : g_bad_lat
        $error("ADD_LAT must be at least one cycle");
    end

    // The adder flags carry the same information as comparing its result
    // against the zero and NaR patterns, which is done on the final sum.
    logic unused_adder_flags;
    assign unused_adder_flags = &{1'b0, add_inf, add_zero};

    acc_state_t       state, state_next;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] inflight, inflight_next;
    logic [N-1:0]     hold;
    logic             hold_v;

    logic             beat;
    logic             consume;
    logic             issue;
    logic [N-1:0]     op_a, op_b;
    logic             hold_load, hold_clear;
    logic             final_load;
    logic [N-1:0]     final_val;
    logic             out_accept;

    assign s_ready    = (state == ACCUM);
    assign m_valid    = (state == OUTPUT);
    assign out_accept = (state == OUTPUT) && m_ready;

    // Next-state and issue decision: pairs operands from the stream, the
    // holding register and the adder output so no partial sum is lost.
    always_comb begin
        state_next = state;
        beat       = 1'b0;
        consume    = 1'b0;
        issue      = 1'b0;
        op_a       = ZERO;
        op_b       = ZERO;
        hold_load  = 1'b0;
        hold_clear = 1'b0;
        final_load = 1'b0;
        final_val  = hold;
        case (state)
            FLUSH: begin
                if (flush_cnt == FLUSH_LAST) state_next = ACCUM;
            end
            ACCUM: begin
                beat    = s_valid;
                consume = add_done;
                if (s_valid && add_done) begin
                    issue = 1'b1;
                    op_a  = s_data;
                    op_b  = add_result;
                end else if (s_valid && hold_v) begin
                    issue      = 1'b1;
                    op_a       = s_data;
                    op_b       = hold;
                    hold_clear = 1'b1;
                end else if (s_valid) begin
                    issue = 1'b1;
                    op_a  = s_data;
                    op_b  = ZERO;
                end else if (add_done && hold_v) begin
                    issue      = 1'b1;
                    op_a       = hold;
                    op_b       = add_result;
                    hold_clear = 1'b1;
                end else if (add_done) begin
                    hold_load = 1'b1;
                end
                if (s_valid && s_last) state_next = DRAIN;
            end
            DRAIN: begin
                consume = add_done;
                if (add_done && hold_v) begin
                    issue      = 1'b1;
                    op_a       = hold;
                    op_b       = add_result;
                    hold_clear = 1'b1;
                end else if (add_done && inflight == ONE) begin
                    final_load = 1'b1;
                    final_val  = add_result;
                    state_next = OUTPUT;
                end else if (add_done) begin
                    hold_load = 1'b1;
                end else if (hold_v && inflight == '0) begin
                    final_load = 1'b1;
                    final_val  = hold;
                    hold_clear = 1'b1;
                    state_next = OUTPUT;
                end
            end
            OUTPUT: begin
                if (m_ready) state_next = ACCUM;
            end
            default: state_next = FLUSH;
        endcase

        inflight_next = inflight;
        if (issue && !consume) begin
            inflight_next = inflight + ONE;
        end else if (!issue && consume && inflight != '0) begin
            inflight_next = inflight - ONE;
        end
    end

    // State register; reset lands in FLUSH so stale adder results are dropped.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= FLUSH;
        else          state <= state_next;
    end

    // Flush timer and the count of adds still travelling through the adder.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            flush_cnt <= '0;
            inflight  <= '0;
        end else begin
            flush_cnt <= (state == FLUSH) ? flush_cnt + ONE : '0;
            inflight  <= out_accept ? '0 : inflight_next;
        end
    end

    // Holding register parks a lone partial sum until a partner arrives.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            hold   <= '0;
            hold_v <= 1'b0;
        end else begin
            if (hold_load) hold <= add_result;
            if (out_accept || hold_clear) hold_v <= 1'b0;
            else if (hold_load)           hold_v <= 1'b1;
        end
    end

    // Registered adder issue port: one start pulse per operand pair.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            add_start <= 1'b0;
            add_in1   <= '0;
            add_in2   <= '0;
        end else begin
            add_start <= issue;
            if (issue) begin
                add_in1 <= op_a;
                add_in2 <= op_b;
            end
        end
    end

    // Final sum and its flags, held steady for the whole output handshake.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_data <= '0;
            m_inf  <= 1'b0;
            m_zero <= 1'b0;
        end else if (final_load) begin
            m_data <= final_val;
            m_inf  <= (final_val == NAR);
            m_zero <= (final_val == ZERO);
        end
    end

`ifdef POSIT_ACC_COUNT_EN
    logic [15:0] beat_cnt;

    // Saturating beat count of the current stream, published with the sum.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_cnt <= '0;
            m_count  <= '0;
        end else begin
            if (out_accept)                        beat_cnt <= '0;
            else if (beat && beat_cnt != 16'hFFFF) beat_cnt <= beat_cnt + 16'd1;
            if (final_load) m_count <= beat_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_posit_stream_accumulator.sv
// Self-checking bench for posit_stream_accumulator: a behavioural posit
// adder stands in for the external adder, and a real-arithmetic stream
// model predicts every sum the accumulator presents.
module tb_posit_stream_accumulator;

    localparam int N       = 8;
    localparam int ES      = 4;
    localparam int ADD_LAT = 6;
    localparam logic [N-1:0] NAR = 8'h80;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic [N-1:0] s_data;
    logic         s_valid;
    logic         s_last;
    logic         s_ready;
    logic [N-1:0] add_in1, add_in2;
    logic         add_start;
    logic [N-1:0] add_result;
    logic         add_inf, add_zero, add_done;
    logic [N-1:0] m_data;
    logic         m_inf, m_zero, m_valid;
    logic         m_ready;
`ifdef POSIT_ACC_COUNT_EN
    logic [15:0]  m_count;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cnt = 0;
    int last_cyc = 0;
    logic [N-1:0] beat_q[$];
    logic [N-1:0] exp_q[$];

    always #5 aclk = ~aclk;

    posit_stream_accumulator #(.N(N), .es(ES), .ADD_LAT(ADD_LAT)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .add_in1    (add_in1),
        .add_in2    (add_in2),
        .add_start  (add_start),
        .add_result (add_result),
        .add_inf    (add_inf),
        .add_zero   (add_zero),
        .add_done   (add_done),
        .m_data     (m_data),
        .m_inf      (m_inf),
        .m_zero     (m_zero),
        .m_valid    (m_valid),
        .m_ready    (m_ready)
`ifdef POSIT_ACC_COUNT_EN
        ,
        .m_count    (m_count)
`endif
    );

    // Posit value arithmetic in plain reals.
    function automatic real pow2(input int e);
        real r;
        r = 1.0;
        if (e >= 0) begin
            for (int i = 0; i < e; i++) r = r * 2.0;
        end else begin
            for (int i = 0; i < -e; i++) r = r / 2.0;
        end
        return r;
    endfunction

    function automatic real decode(input logic [N-1:0] p);
        logic [N-1:0] v;
        bit  r0;
        int  run, i, k, e, pos;
        real f, w, val;
        if (p == '0 || p == NAR) return 0.0;
        v = p[N-1] ? (~p + 1'b1) : p;
        r0 = v[N-2];
        run = 0;
        i = N - 2;
        while (i >= 0 && v[i] == r0) begin
            run++;
            i--;
        end
        k = r0 ? run - 1 : -run;
        e = 0;
        for (int b = 0; b < ES; b++) begin
            pos = i - 1 - b;
            e = e * 2;
            if (pos >= 0 && v[pos] == 1'b1) e++;
        end
        f = 1.0;
        w = 0.5;
        for (pos = i - 1 - ES; pos >= 0; pos--) begin
            if (v[pos] == 1'b1) f = f + w;
            w = w / 2.0;
        end
        val = f * pow2(k * (1 << ES) + e);
        return p[N-1] ? -val : val;
    endfunction

    function automatic real absr(input real x);
        return (x < 0.0) ? -x : x;
    endfunction

    // Nearest representable posit, found by scanning every finite code.
    function automatic logic [N-1:0] encode(input real x);
        logic [N-1:0] best, c;
        real d, bd;
        if (x == 0.0) return '0;
        best = 8'h01;
        bd = absr(decode(best) - x);
        for (int j = 2; j < (1 << N); j++) begin
            if (j == 128) continue;
            c = N'(j);
            d = absr(decode(c) - x);
            if (d < bd) begin
                bd = d;
                best = c;
            end
        end
        return best;
    endfunction

    function automatic logic [N-1:0] model_add(input logic [N-1:0] a, input logic [N-1:0] b);
        if (a == NAR || b == NAR) return NAR;
        return encode(decode(a) + decode(b));
    endfunction

    // Expected sum of the whole stream in beat_q.
    function automatic logic [N-1:0] model_stream();
        real sum;
        sum = 0.0;
        foreach (beat_q[j]) begin
            if (beat_q[j] == NAR) return NAR;
            sum = sum + decode(beat_q[j]);
        end
        return encode(sum);
    endfunction

    // Stand-in for the reset-less external adder with ADD_LAT latency.
    logic [ADD_LAT-1:0] pipe_v = '0;
    logic [N-1:0]       pipe_data [ADD_LAT] = '{default: '0};

    always @(posedge aclk) begin
        pipe_v <= {pipe_v[ADD_LAT-2:0], add_start};
        pipe_data[0] <= add_start ? model_add(add_in1, add_in2) : '0;
        for (int i = 1; i < ADD_LAT; i++) pipe_data[i] <= pipe_data[i-1];
    end

    assign add_done   = pipe_v[ADD_LAT-1];
    assign add_result = pipe_data[ADD_LAT-1];
    assign add_inf    = (add_result == NAR);
    assign add_zero   = (add_result == '0);

    // Cycle and issue counters used for latency and start-pulse checks.
    always @(posedge aclk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(negedge aclk);
            if (add_start) start_cnt = start_cnt + 1;
        end
    end

    // Every cycle: handshake exclusivity, and any presented sum against the model.
    initial begin
        forever begin
            @(negedge aclk);
            if (aresetn) begin
                checks++;
                if (s_ready && m_valid) begin
                    errors++;
                    $display("[TB] FAIL ready_valid_excl actual s_ready=%0b m_valid=%0b required not both high", s_ready, m_valid);
                end
                if (m_valid) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL model_sum actual m_data=%02h required no result pending", m_data);
                    end else begin
                        if (m_data !== exp_q[0] || m_inf !== (exp_q[0] == NAR) || m_zero !== (exp_q[0] == '0)) begin
                            errors++;
                            $display("[TB] FAIL model_sum actual %02h/inf%0b/zero%0b required %02h/inf%0b/zero%0b",
                                     m_data, m_inf, m_zero, exp_q[0], exp_q[0] == NAR, exp_q[0] == '0);
                        end
                        if (m_ready) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Drives the stream held in beat_q, optionally registering its expected sum.
    task automatic applyStimulus(input int gap, input bit expect_res);
        int  tries;
        bit  accepted;
        if (expect_res) exp_q.push_back(model_stream());
        @(posedge aclk);
        #2;
        for (int i = 0; i < beat_q.size(); i++) begin
            s_valid = 1'b1;
            s_data  = beat_q[i];
            s_last  = (i == beat_q.size() - 1);
            tries = 0;
            accepted = 1'b0;
            while (!accepted && tries < 100) begin
                @(negedge aclk);
                if (s_ready) accepted = 1'b1;
                else tries++;
            end
            checkOutput("beat_accept", 32'(accepted), 32'd1);
            if (s_last) last_cyc = cyc;
            @(posedge aclk);
            #2;
            s_valid = 1'b0;
            s_last  = 1'b0;
            for (int g = 0; g < gap; g++) begin
                @(posedge aclk);
                #2;
            end
        end
    endtask

    // Waits for the sum, pins it to a hand-computed literal, stalls, then accepts.
    task automatic waitResult(input string name, input logic [N-1:0] exp_data, input int hold_cycles);
        int tries;
        int min_lat;
        tries = 0;
        while (tries < 400) begin
            @(negedge aclk);
            if (m_valid) break;
            tries++;
        end
        checkOutput({name, "_valid"}, 32'(m_valid), 32'd1);
        if (!m_valid) return;
        min_lat = (ADD_LAT + 1) * $clog2(beat_q.size()) + 1;
        checkOutput({name, "_latency_ok"}, 32'(cyc - last_cyc >= min_lat), 32'd1);
        checkOutput({name, "_data"}, 32'(m_data), 32'(exp_data));
        checkOutput({name, "_inf"}, 32'(m_inf), 32'(exp_data == NAR));
        checkOutput({name, "_zero"}, 32'(m_zero), 32'(exp_data == '0));
`ifdef POSIT_ACC_COUNT_EN
        checkOutput({name, "_count"}, 32'(m_count), 32'(beat_q.size()));
`endif
        for (int h = 0; h < hold_cycles; h++) begin
            @(negedge aclk);
            checkOutput({name, "_stall_data"}, 32'(m_data), 32'(exp_data));
            checkOutput({name, "_stall_sready"}, 32'(s_ready), 32'd0);
        end
        @(posedge aclk);
        #2;
        m_ready = 1'b1;
        @(posedge aclk);
        #2;
        m_ready = 1'b0;
        @(negedge aclk);
        checkOutput({name, "_valid_drop"}, 32'(m_valid), 32'd0);
        checkOutput({name, "_sready_after"}, 32'(s_ready), 32'd1);
    endtask

    task automatic measureFlush(input string name);
        int cnt;
        cnt = 0;
        while (cnt < 50) begin
            @(negedge aclk);
            if (s_ready) break;
            cnt++;
        end
        checkOutput(name, 32'(cnt), 32'(ADD_LAT + 1));
    endtask

    initial begin
        int s0;
        s_data  = '0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b0;

        // Pin the model itself to hand-computed posit sums.
        beat_q = '{8'h40, 8'h40, 8'h40, 8'h40};
        checkOutput("model_four_ones", 32'(model_stream()), 32'h44);
        beat_q = '{8'h40, 8'hC0};
        checkOutput("model_cancel", 32'(model_stream()), 32'h00);
        beat_q = '{8'h40, 8'h80, 8'h40};
        checkOutput("model_nar", 32'(model_stream()), 32'h80);
        checkOutput("model_add_1p1", 32'(model_add(8'h40, 8'h40)), 32'h42);
        checkOutput("model_add_1p0", 32'(model_add(8'h40, 8'h00)), 32'h40);

        // Reset values.
        repeat (2) @(negedge aclk);
        checkOutput("rst_s_ready", 32'(s_ready), 32'd0);
        checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
        checkOutput("rst_add_start", 32'(add_start), 32'd0);
        checkOutput("rst_add_in1", 32'(add_in1), 32'd0);
        checkOutput("rst_add_in2", 32'(add_in2), 32'd0);
        checkOutput("rst_m_data", 32'(m_data), 32'd0);
        checkOutput("rst_m_inf", 32'(m_inf), 32'd0);
        checkOutput("rst_m_zero", 32'(m_zero), 32'd0);

        @(posedge aclk);
        #2;
        aresetn = 1'b1;
        measureFlush("flush_len");

        $display("[TB] single beat");
        beat_q = '{8'h40};
        s0 = start_cnt;
        applyStimulus(0, 1'b1);
        waitResult("single", 8'h40, 0);
        checkOutput("single_starts", 32'(start_cnt - s0), 32'd1);

        $display("[TB] four back-to-back ones");
        beat_q = '{8'h40, 8'h40, 8'h40, 8'h40};
        applyStimulus(0, 1'b1);
        waitResult("four", 8'h44, 0);

        $display("[TB] cancel to zero");
        beat_q = '{8'h40, 8'hC0};
        applyStimulus(0, 1'b1);
        waitResult("cancel", 8'h00, 0);

        $display("[TB] NaR propagation");
        beat_q = '{8'h40, 8'h80, 8'h40};
        applyStimulus(0, 1'b1);
        waitResult("nar", 8'h80, 0);

        $display("[TB] gapped beats with output stall");
        beat_q = '{8'h40, 8'h40};
        applyStimulus(3, 1'b1);
        waitResult("stall", 8'h42, 10);

        $display("[TB] reset during drain");
        beat_q = '{8'h40, 8'h40, 8'h40};
        applyStimulus(0, 1'b0);
        repeat (3) @(posedge aclk);
        #2;
        aresetn = 1'b0;
        #1;
        checkOutput("midrst_s_ready", 32'(s_ready), 32'd0);
        checkOutput("midrst_add_start", 32'(add_start), 32'd0);
        checkOutput("midrst_add_in1", 32'(add_in1), 32'd0);
        checkOutput("midrst_m_valid", 32'(m_valid), 32'd0);
        @(posedge aclk);
        #2;
        aresetn = 1'b1;
        measureFlush("midrst_flush_len");
        beat_q = '{8'h40, 8'h40};
        applyStimulus(0, 1'b1);
        waitResult("post_reset", 8'h42, 0);

        repeat (20) @(negedge aclk);
        checkOutput("results_consumed", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
